// File: rtl/i2s_tx_mch_fifo_pkg.sv
// rtl/i2s_tx_mch_fifo_pkg.sv - shared types and helpers for the multichannel I2S transmit FIFO
//
// Contents:
//   frame_sz_t : frame size code (16/24/32 bits, code 3 also means 32)
//   tx_st_t    : serializer states
//   FS_W       : width of a frame length / bit counter
//   fsize()    : frame size code -> number of bits per frame
package i2s_tx_mch_fifo_pkg;

    typedef enum logic [1:0] {
        f16bits = 2'd0,
        f24bits = 2'd1,
        f32bits = 2'd2
    } frame_sz_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } tx_st_t;

    localparam int FS_W = 6;

    function automatic logic [FS_W-1:0] fsize(input logic [1:0] frame_sz);
        logic [FS_W-1:0] fs;
        case (frame_sz)
            f16bits: fs = 6'd16;
            f24bits: fs = 6'd24;
            default: fs = 6'd32;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/i2s_ser_shifter.sv
// rtl/i2s_ser_shifter.sv - left-justified parallel-to-serial shifter with bit counter
//
// Ports:
//   pclk, rst   : clock, synchronous active-high reset
//   load        : capture ld_word (top fs bits kept), restart bit counter, pulse word_start
//   shift       : move to the next bit
//   clr         : return to the silent state (shift register and counter zero)
//   mute        : gates sdout low without disturbing the shift register
//   frame_sz    : frame size code, sampled on load
//   ld_word     : word to serialize, MSB aligned to bit WIDTH-1
//   sdout       : serial data, MSB first
//   word_start  : high for the cycle in which the first bit of a word is shown
//   bitcnt_zero : current bit is the last of its word (or nothing loaded)
module i2s_ser_shifter
    import i2s_tx_mch_fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic             mute,
    input  logic [1:0]       frame_sz,
    input  logic [WIDTH-1:0] ld_word,
    output logic             sdout,
    output logic             word_start,
    output logic             bitcnt_zero
);

    logic [WIDTH-1:0] sh_q;
    logic [FS_W-1:0]  bitcnt_q;
    logic [FS_W-1:0]  fs;
    logic [WIDTH-1:0] keep_mask;

    // Only the top fs bits of the word belong to the frame; the rest are zeroed
    // so a short frame never leaks stale low bits.
    always_comb begin
        fs        = fsize(frame_sz);
        keep_mask = ~({WIDTH{1'b1}} >> fs);
    end

    always_ff @(posedge pclk) begin
        if (rst || clr) begin
            sh_q       <= '0;
            bitcnt_q   <= '0;
            word_start <= 1'b0;
        end else begin
            word_start <= load;
            if (load) begin
                sh_q     <= ld_word & keep_mask;
                bitcnt_q <= fs - FS_W'(1);
            end else if (shift) begin
                sh_q     <= {sh_q[WIDTH-2:0], 1'b0};
                bitcnt_q <= bitcnt_q - FS_W'(1);
            end
        end
    end

    assign sdout       = sh_q[WIDTH-1] & ~mute;
    assign bitcnt_zero = (bitcnt_q == '0);

endmodule

// File: rtl/i2s_tx_mch_fifo.sv
// rtl/i2s_tx_mch_fifo.sv - multichannel I2S transmit FIFO with built-in serializer
//
// Optional build macro: TXF_REPEAT_ON_UNDERRUN_EN (repeat the channel's last word on underrun
// instead of sending zeros).
//
// Ports:
//   pclk, rst              : clock, synchronous active-high reset
//   run                    : serializer enable
//   wr_en, din, din_ch     : push request, sample word, channel tag
//   bit_en                 : one strobe per serial bit period
//   frame_sz               : 0=16, 1=24, 2/3=32 bits, sampled at each word load
//   mute                   : forces sdout low, shifting continues
//   thr_afull, thr_aempty  : almost-full / almost-empty thresholds
//   clr_err                : clears the sticky error flags
//   sdout, word_start      : serial data (MSB first), first-bit pulse
//   ch_out                 : channel of the word being shifted
//   count                  : occupancy
//   full, empty, al_full, al_empty : status flags
//   underrun, order_err    : sticky errors
module i2s_tx_mch_fifo
    import i2s_tx_mch_fifo_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  ADDR  = 3,
    parameter int  NCH   = 2,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             run,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic [CHW-1:0]   din_ch,
    input  logic             bit_en,
    input  logic [1:0]       frame_sz,
    input  logic             mute,
    input  logic [ADDR:0]    thr_afull,
    input  logic [ADDR:0]    thr_aempty,
    input  logic             clr_err,
    output logic             sdout,
    output logic             word_start,
    output logic [CHW-1:0]   ch_out,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             empty,
    output logic             al_full,
    output logic             al_empty,
    output logic             underrun,
    output logic             order_err
);

    localparam int             DEPTH   = 1 << ADDR;
    localparam logic [ADDR:0]  DEPTH_C = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0]  PTR_ONE = {{ADDR{1'b0}}, 1'b1};
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

    function automatic logic [CHW-1:0] ch_inc(input logic [CHW-1:0] c);
        return (c == CH_LAST) ? '0 : c + CHW'(1);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR:0]    wptr_q, rptr_q;
    logic [CHW-1:0]   wr_ch_exp_q;
    logic [CHW-1:0]   ch_out_q, ch_nxt_q;
    logic             underrun_q, order_err_q;
    tx_st_t           st_q, st_d;

    logic             push, ord_set;
    logic             pop, load, shift, ser_clr, urun_set;
    logic             bitcnt_zero;
    logic [WIDTH-1:0] rd_data, urun_word, ld_word;

    // ---------------- FIFO core ----------------
    // Pointers carry one extra wrap bit so full and empty differ in count.
    assign count    = wptr_q - rptr_q;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign al_full  = (count >= thr_afull);
    assign al_empty = (count <= thr_aempty);

    // A push while full is silently dropped; only a mis-ordered push that
    // could otherwise have been accepted counts as an order error.
    assign push    = wr_en && !full && (din_ch == wr_ch_exp_q);
    assign ord_set = wr_en && !full && (din_ch != wr_ch_exp_q);
    assign rd_data = mem[rptr_q[ADDR-1:0]];

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wptr_q[ADDR-1:0]] <= din;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wr_ch_exp_q <= '0;
        end else begin
            if (push) begin
                wptr_q      <= wptr_q + PTR_ONE;
                wr_ch_exp_q <= ch_inc(wr_ch_exp_q);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // ---------------- serializer control ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        load     = 1'b0;
        shift    = 1'b0;
        ser_clr  = 1'b0;
        pop      = 1'b0;
        urun_set = 1'b0;
        case (st_q)
            IDLE: begin
                if (run && !empty) begin
                    st_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt_zero) begin
                    // Word boundary: stop cleanly or fetch the next word.
                    if (bit_en) begin
                        if (!run) begin
                            st_d    = IDLE;
                            ser_clr = 1'b1;
                        end else begin
                            load     = 1'b1;
                            pop      = !empty;
                            urun_set = empty;
                        end
                    end
                end else begin
                    shift = bit_en;
                    if (!run) begin
                        st_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bit_en) begin
                    if (bitcnt_zero) begin
                        st_d    = IDLE;
                        ser_clr = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Channel rotation advances on every load, including underrun loads, so
    // slot alignment survives a starved FIFO; it restarts at 0 after a stop.
    always_ff @(posedge pclk) begin
        if (rst || ser_clr) begin
            ch_out_q <= '0;
            ch_nxt_q <= '0;
        end else if (load) begin
            ch_out_q <= ch_nxt_q;
            ch_nxt_q <= ch_inc(ch_nxt_q);
        end
    end

    assign ch_out = ch_out_q;

`ifdef TXF_REPEAT_ON_UNDERRUN_EN
    logic [WIDTH-1:0] last_q [NCH];

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                last_q[i] <= '0;
            end
        end else if (pop) begin
            last_q[ch_nxt_q] <= rd_data;
        end
    end

    assign urun_word = last_q[ch_nxt_q];
`else
    assign urun_word = '0;
`endif

    assign ld_word = pop ? rd_data : urun_word;

    // ---------------- sticky errors (set beats clear) ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            underrun_q  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            if (urun_set) begin
                underrun_q <= 1'b1;
            end else if (clr_err) begin
                underrun_q <= 1'b0;
            end
            if (ord_set) begin
                order_err_q <= 1'b1;
            end else if (clr_err) begin
                order_err_q <= 1'b0;
            end
        end
    end

    assign underrun  = underrun_q;
    assign order_err = order_err_q;

    i2s_ser_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .pclk        (pclk),
        .rst         (rst),
        .load        (load),
        .shift       (shift),
        .clr         (ser_clr),
        .mute        (mute),
        .frame_sz    (frame_sz),
        .ld_word     (ld_word),
        .sdout       (sdout),
        .word_start  (word_start),
        .bitcnt_zero (bitcnt_zero)
    );

endmodule
